// File: rtl/vga_fb_window_scaler_if.sv
// Signal bundle between the VGA raster source, the frame-buffer read port and the pixel output.
// The slave modport is the scaler; the master modport is the surrounding system.
interface vga_fb_window_scaler_if #(
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
);
    logic [CNT_W-1:0]  x_cnt;
    logic [CNT_W-1:0]  y_cnt;
    logic              vidon;
    logic [CNT_W-1:0]  win_x;
    logic [CNT_W-1:0]  win_y;
    logic [1:0]        scale_mode;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [PIX_W-1:0]  ram_data;
    logic [PIX_W-1:0]  rgb;
    logic              rgb_valid;
    logic              frame_start;

    modport slave (
        input  x_cnt, y_cnt, vidon, win_x, win_y, scale_mode, ram_data,
        output addr, addr_valid, rgb, rgb_valid, frame_start
    );

    modport master (
        output x_cnt, y_cnt, vidon, win_x, win_y, scale_mode, ram_data,
        input  addr, addr_valid, rgb, rgb_valid, frame_start
    );
endinterface

// File: rtl/vga_fb_window_scaler.sv
// Places a camera frame buffer as a 1x/2x/4x window on the VGA raster.
// It generates read addresses with counters and muxes frame data, background or blank.
module vga_fb_window_scaler #(
    parameter int               FB_W     = 320,
    parameter int               FB_H     = 240,
    parameter int               ADDR_W   = 17,
    parameter int               PIX_W    = 12,
    parameter int               CNT_W    = 10,
    parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
    input logic                   clk,
    input logic                   rst,
    vga_fb_window_scaler_if.slave bus
);
    localparam int CW = CNT_W + 3;

    logic [CNT_W-1:0]  wx_q, wx_d, wy_q, wy_d;
    logic [1:0]        s_q, s_d, mask;
    logic [CNT_W-1:0]  col_q, col_d, col_cur;
    logic [1:0]        subx_q, subx_d, subx_cur;
    logic [1:0]        suby_q, suby_d;
    logic [ADDR_W-1:0] lb_q, lb_d;
    logic              row_pend_q, row_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              av_q, av_d;
    logic              fs_q, fs_d;
    logic [1:0]        vld_pipe_q, vld_pipe_d;
    logic [PIX_W-1:0]  rgb_q, rgb_d;

    logic              fs, line_start, in_x, in_y, in_rng, in_win;
    logic [CW-1:0]     xe, ye, x_lo, x_hi, y_lo, y_hi;

    always_comb begin
        fs         = (bus.x_cnt == '0) && (bus.y_cnt == '0);
        line_start = (bus.x_cnt == '0);

        // At frame start the live configuration applies to this very pixel.
        wx_d = fs ? bus.win_x : wx_q;
        wy_d = fs ? bus.win_y : wy_q;
        s_d  = s_q;
        if (fs) s_d = (bus.scale_mode == 2'b00) ? 2'd0 :
                      (bus.scale_mode == 2'b01) ? 2'd1 : 2'd2;
        mask = (s_d == 2'd0) ? 2'd0 : (s_d == 2'd1) ? 2'd1 : 2'd3;

        xe     = CW'(bus.x_cnt);
        ye     = CW'(bus.y_cnt);
        x_lo   = CW'(wx_d);
        y_lo   = CW'(wy_d);
        x_hi   = x_lo + (CW'(FB_W) << s_d);
        y_hi   = y_lo + (CW'(FB_H) << s_d);
        in_x   = (xe >= x_lo) && (xe < x_hi);
        in_y   = (ye >= y_lo) && (ye < y_hi);
        in_rng = in_x && in_y;
        in_win = bus.vidon && in_rng;

        // Row state steps at the start of the line following a window line.
        lb_d   = lb_q;
        suby_d = suby_q;
        if (fs || (line_start && !in_y)) begin
            lb_d   = '0;
            suby_d = '0;
        end else if (line_start && row_pend_q) begin
            if (suby_q == mask) begin
                suby_d = '0;
                lb_d   = lb_q + ADDR_W'(FB_W);
            end else begin
                suby_d = suby_q + 2'd1;
            end
        end
        row_pend_d = (line_start ? 1'b0 : row_pend_q) || in_rng;

        // Column restarts on the window's left edge, so no per-line cleanup is needed.
        col_cur  = (bus.x_cnt == wx_d) ? '0 : col_q;
        subx_cur = (bus.x_cnt == wx_d) ? '0 : subx_q;
        col_d    = '0;
        subx_d   = '0;
        if (in_rng) begin
            if (subx_cur == mask) begin
                col_d = col_cur + CNT_W'(1);
            end else begin
                col_d  = col_cur;
                subx_d = subx_cur + 2'd1;
            end
        end

        addr_d     = in_win ? (lb_d + ADDR_W'(col_cur)) : addr_q;
        av_d       = in_win;
        fs_d       = fs;
        vld_pipe_d = {vld_pipe_q[0], bus.vidon};
        rgb_d      = av_q ? bus.ram_data : (vld_pipe_q[0] ? BG_COLOR : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wx_q       <= '0;
            wy_q       <= '0;
            s_q        <= '0;
            col_q      <= '0;
            subx_q     <= '0;
            suby_q     <= '0;
            lb_q       <= '0;
            row_pend_q <= 1'b0;
            addr_q     <= '0;
            av_q       <= 1'b0;
            fs_q       <= 1'b0;
            vld_pipe_q <= '0;
            rgb_q      <= '0;
        end else begin
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            s_q        <= s_d;
            col_q      <= col_d;
            subx_q     <= subx_d;
            suby_q     <= suby_d;
            lb_q       <= lb_d;
            row_pend_q <= row_pend_d;
            addr_q     <= addr_d;
            av_q       <= av_d;
            fs_q       <= fs_d;
            vld_pipe_q <= vld_pipe_d;
            rgb_q      <= rgb_d;
        end
    end

    assign bus.addr        = addr_q;
    assign bus.addr_valid  = av_q;
    assign bus.rgb         = rgb_q;
    assign bus.rgb_valid   = vld_pipe_q[1];
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_fb_window_scaler.sv
// Bench for vga_fb_window_scaler: a reference mapping model feeds a scoreboard.
// It also checks directed coordinate points.
module tb_vga_fb_window_scaler;
    localparam int          FB_W   = 320;
    localparam int          FB_H   = 240;
    localparam int          ADDR_W = 17;
    localparam int          PIX_W  = 12;
    localparam int          CNT_W  = 10;
    localparam logic [11:0] BG     = 12'h0F0;

    typedef struct { logic v; logic [16:0] a; logic f; int x; int y; } a_exp_t;
    typedef struct { logic v; logic [11:0] p; int x; int y; } r_exp_t;
    typedef struct { int x; int y; bit is_rgb; logic v; logic [16:0] val; } pt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_fb_window_scaler_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    vga_fb_window_scaler #(
        .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CNT_W(CNT_W), .BG_COLOR(BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Frame-buffer contents: addr 5 holds ABC, everything else a pattern of the address.
    function automatic logic [11:0] mem_fn(input logic [16:0] a);
        return (a == 17'd5) ? 12'hABC : (a[11:0] ^ 12'h3C5);
    endfunction
    assign bus.ram_data = mem_fn(bus.addr);

    a_exp_t      qa[$];
    r_exp_t      qr[$];
    pt_t         pts[$];
    int          total = 0;
    int          bad   = 0;
    int          m_wx = 0, m_wy = 0, m_s = 0;
    logic [16:0] m_addr = '0;
    int          vx0 = 144, vx1 = 784, vy0 = 35, vy1 = 515;

    task automatic chk(input string tag, input int x, input int y,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s at (%0d,%0d): got %0h expected %0h", tag, x, y, got, exp);
        end
    endtask

    task automatic pt(input int x, input int y, input bit is_rgb, input logic v, input int val);
        pts.push_back('{x, y, is_rgb, v, 17'(val)});
    endtask

    task automatic step(input int x, input int y, input bit r);
        a_exp_t ea;
        r_exp_t er;
        logic   vid, inw;
        @(negedge clk);
        rst       = r;
        bus.x_cnt = x[CNT_W-1:0];
        bus.y_cnt = y[CNT_W-1:0];
        vid       = (x >= vx0) && (x < vx1) && (y >= vy0) && (y < vy1);
        bus.vidon = vid;
        if (r) begin
            m_wx = 0; m_wy = 0; m_s = 0; m_addr = '0;
            qr.delete();
            qr.push_back('{1'b0, 12'h000, -1, -1});
            qr.push_back('{1'b0, 12'h000, -1, -1});
            ea = '{1'b0, 17'd0, 1'b0, x, y};
        end else begin
            if (x == 0 && y == 0) begin
                m_wx = int'(bus.win_x);
                m_wy = int'(bus.win_y);
                m_s  = (bus.scale_mode == 2'b00) ? 0 : (bus.scale_mode == 2'b01) ? 1 : 2;
            end
            inw = vid && (x >= m_wx) && (x < m_wx + (FB_W << m_s)) &&
                  (y >= m_wy) && (y < m_wy + (FB_H << m_s));
            if (inw) m_addr = 17'(((y - m_wy) >> m_s) * FB_W + ((x - m_wx) >> m_s));
            ea = '{inw, m_addr, (x == 0 && y == 0), x, y};
            er = '{vid, inw ? mem_fn(m_addr) : (vid ? BG : 12'h000), x, y};
            qr.push_back(er);
        end
        qa.push_back(ea);

        @(posedge clk);
        #1;
        ea = qa.pop_front();
        chk("addr_valid", ea.x, ea.y, bus.addr_valid, ea.v);
        chk("addr", ea.x, ea.y, bus.addr, ea.a);
        chk("frame_start", ea.x, ea.y, bus.frame_start, ea.f);
        foreach (pts[i]) if (!pts[i].is_rgb && pts[i].x == ea.x && pts[i].y == ea.y) begin
            chk("pt_addr_valid", ea.x, ea.y, bus.addr_valid, pts[i].v);
            if (pts[i].v) chk("pt_addr", ea.x, ea.y, bus.addr, pts[i].val);
        end
        if (qr.size() >= 2) begin
            er = qr.pop_front();
            chk("rgb_valid", er.x, er.y, bus.rgb_valid, er.v);
            chk("rgb", er.x, er.y, bus.rgb, er.p);
            foreach (pts[i]) if (pts[i].is_rgb && pts[i].x == er.x && pts[i].y == er.y) begin
                chk("pt_rgb_valid", er.x, er.y, bus.rgb_valid, pts[i].v);
                chk("pt_rgb", er.x, er.y, bus.rgb, pts[i].val);
            end
        end
    endtask

    // A line is its x=0 start cycle plus a contiguous segment around the area of interest.
    task automatic line(input int y, input int x0, input int x1);
        step(0, y, 1'b0);
        for (int x = (x0 < 1 ? 1 : x0); x <= x1; x++) step(x, y, 1'b0);
    endtask

    task automatic cfg(input int wx, input int wy, input logic [1:0] sm);
        bus.win_x      = wx[CNT_W-1:0];
        bus.win_y      = wy[CNT_W-1:0];
        bus.scale_mode = sm;
    endtask

    initial begin
        bus.x_cnt = '0; bus.y_cnt = '0; bus.vidon = 1'b0;
        cfg(144, 35, 2'b01);

        step(5, 5, 1'b1);
        step(5, 5, 1'b1);

        // 2x window at (144,35)
        pt(144, 35, 0, 1, 0);   pt(145, 35, 0, 1, 0);   pt(146, 35, 0, 1, 1);
        pt(144, 36, 0, 1, 0);   pt(144, 37, 0, 1, 320); pt(783, 514, 0, 1, 76799);
        pt(143, 35, 0, 0, 0);   pt(784, 35, 0, 0, 0);
        for (int y = 0; y <= 514; y++)
            if (y == 35 || y == 514) line(y, 143, 785); else line(y, 143, 146);

        // 1x window at (200,100)
        pts.delete();
        cfg(200, 100, 2'b00);
        pt(200, 100, 0, 1, 0);  pt(519, 100, 0, 1, 319); pt(200, 101, 0, 1, 320);
        pt(520, 100, 1, 1, int'(BG));
        for (int y = 0; y <= 101; y++)
            if (y == 100) line(y, 199, 521); else line(y, 199, 201);

        // 4x at origin, then scale_mode 11 must map identically
        pts.delete();
        vx0 = 0; vx1 = 640; vy0 = 0; vy1 = 480;
        pt(3, 0, 0, 1, 0); pt(4, 0, 0, 1, 1); pt(0, 4, 0, 1, 320);
        cfg(0, 0, 2'b10);
        for (int y = 0; y <= 4; y++) line(y, 0, 8);
        cfg(0, 0, 2'b11);
        for (int y = 0; y <= 4; y++) line(y, 0, 8);

        // read latency and blanking
        pts.delete();
        vx1 = 8;
        cfg(0, 0, 2'b00);
        pt(5, 0, 0, 1, 5); pt(5, 0, 1, 1, 12'hABC); pt(8, 0, 1, 0, 0);
        for (int y = 0; y <= 1; y++) line(y, 0, 10);

        // mid-frame reconfiguration waits for the next frame start
        pts.delete();
        vx1 = 640;
        pt(0, 1, 0, 1, 320); pt(4, 1, 0, 1, 324);
        line(0, 0, 6);
        cfg(4, 0, 2'b01);
        line(1, 0, 6);
        pts.delete();
        pt(3, 0, 0, 0, 0); pt(4, 0, 0, 1, 0); pt(5, 0, 0, 1, 0); pt(6, 0, 0, 1, 1);
        line(0, 0, 8);

        // reset in the middle of a window line
        pts.delete();
        vx0 = 144; vx1 = 784; vy0 = 35; vy1 = 515;
        cfg(144, 35, 2'b01);
        for (int y = 0; y < 300; y++) line(y, 143, 146);
        step(0, 300, 1'b0);
        for (int x = 143; x <= 300; x++) step(x, 300, 1'b0);
        step(301, 300, 1'b1);
        for (int x = 302; x <= 340; x++) step(x, 300, 1'b0);
        line(301, 143, 146);
        pt(144, 35, 0, 1, 0); pt(146, 35, 0, 1, 1); pt(144, 37, 0, 1, 320);
        for (int y = 0; y <= 37; y++) line(y, 143, 146);

        for (int i = 0; i < 3; i++) step(1, 600, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
